cla_seq_ctrl: RTL and testbench
===============================

// Module: cla_seq_ctrl
// PURPOSE
//  Multi-cycle add/subtract controller. It time-shares one CHUNK-bit carry-lookahead slice
//  across a WIDTH-bit operation, processing chunks LSB-first, one chunk per cycle.
//  The slice uses per-bit propagate (a^b) and generate (a&b) terms.
//  The controller sequences the chunk index and holds the inter-chunk carry.
//  It collects the result and hands it off through valid/ready on both sides.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK    8  slice width in bits; NCHUNK = WIDTH/CHUNK (NCHUNK >= 1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      controller can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: compute a - b (= a + ~b + 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, two's-complement wrap-around
//  cout       out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB ^ carry out of MSB
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0,
//    out_valid=0, in_ready=1, busy=0. Any operation in flight is discarded, with no output.
//  - States:
//    - IDLE: in_ready=1. On in_valid&in_ready:
//      - capture a, b^{WIDTH{sub}}, and carry=sub|cin (sub overrides cin);
//      - set idx=0 and go to RUN.
//    - RUN: in_ready=0. Each edge, the slice computes chunk idx:
//      - p=a^b, g=a&b; c[i+1]=g[i]|p[i]&c[i], with c[0]=carry;
//      - write sum[idx*CHUNK +: CHUNK]=p^c[CHUNK-1:0]; set carry=c[CHUNK]; idx++.
//      - On the edge processing idx==NCHUNK-1: also load cout=c[CHUNK] and
//        ovf=c[CHUNK-1]^c[CHUNK], then go to DONE.
//    - DONE: out_valid=1, in_ready=0. sum, cout and ovf stay stable while out_valid=1
//      and out_ready=0. On out_valid&out_ready, go to IDLE and clear out_valid on that edge.
//  - Latency: out_valid rises NCHUNK edges after the accept edge.
//    - Throughput is one op per NCHUNK+2 cycles; there is no accept in the same cycle as a DONE handoff.
//  - a/b/cin/sub are sampled only at the accept edge; later changes have no effect.
//  - sum bits are updated in place chunk by chunk. sum is only meaningful while out_valid=1.
//  - idx is a $clog2(NCHUNK)-bit counter (1 bit when NCHUNK=1). It never wraps within an op.
//  - in_valid with no accept (state != IDLE) is ignored, not queued. The producer holds it.
//  - out_ready while out_valid=0 has no effect.
//  - NCHUNK=1: RUN lasts one cycle, so out_valid rises 1 edge after accept.
// TESTING
//  1 a=0x0000_0003 b=0x0000_0004 cin=0 sub=0 -> sum=0x0000_0007, cout=0, ovf=0,
//    out_valid exactly 4 edges after accept.
//  2 a=0xFFFF_FFFF b=0x0000_0001 cin=0 -> sum=0x0000_0000, cout=1, ovf=0
//    (carry ripples across all 4 chunks).
//  3 a=0x7FFF_FFFF b=0x0000_0000 cin=1 -> sum=0x8000_0000, cout=0, ovf=1;
//    sub=1, a=5, b=7, cin=0 -> sum=0xFFFF_FFFE, cout=0.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and sum held,
//    in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
//  5 rst_n low during RUN at idx=2 -> all outputs go to reset values immediately.
//    After release, a new op a=1,b=1 gives sum=2 with no stale chunks.
//  6 Change a/b every cycle during RUN, and hold in_valid=1 in RUN/DONE
//    -> result matches operands captured at the accept edge; no second accept before IDLE.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: multi-cycle add/subtract controller. One CHUNK-bit
// carry-lookahead slice is reused across the WIDTH-bit operands. It handles
// one chunk per cycle, LSB first, and carries the inter-chunk carry in a flop.
module cla_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;        // already inverted for subtraction
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;

   logic [CHUNK-1:0]  a_chunk_s;
   logic [CHUNK-1:0]  b_chunk_s;
   logic [CHUNK-1:0]  p_s;
   logic [CHUNK-1:0]  g_s;
   logic [CHUNK:0]    c_s;

   // Slice: propagate/generate terms and carry chain for the current chunk.
   always_comb begin
      a_chunk_s = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk_s = b_q[idx_q*CHUNK +: CHUNK];
      p_s       = a_chunk_s ^ b_chunk_s;
      g_s       = a_chunk_s & b_chunk_s;
      c_s       = '0;
      c_s[0]    = carry_q;
      for (int i = 0; i < CHUNK; i++) begin
         c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
      end
   end

   // Controller: next state, chunk sequencing and result collection.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub | cin;      // subtraction forces the +1
               idx_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            sum_d[idx_q*CHUNK +: CHUNK] = p_s ^ c_s[CHUNK-1:0];
            carry_d = c_s[CHUNK];
            if (idx_q == LAST_IDX) begin
               cout_d      = c_s[CHUNK];
               ovf_d       = c_s[CHUNK-1] ^ c_s[CHUNK];
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      in_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Testbench for cla_seq_ctrl: directed operations, each checked against
// hand-computed values. A behavioural reference model is also compared on
// every cycle.
module tb_cla_seq_ctrl;

   localparam int W      = 32;
   localparam int C      = 8;
   localparam int NCHUNK = W / C;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   cla_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain wide arithmetic, returns {ovf, cout, sum}.
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic s);
      logic [W-1:0] yy;
      logic         c0;
      logic [W:0]   full;
      logic [W-1:0] low;
      yy   = s ? ~y : y;
      c0   = s ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + (W+1)'(c0);
      low  = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(c0);
      return {low[W-1] ^ full[W], full[W], full[W-1:0]};
   endfunction

   // Model: 0 idle, 1 computing (count down NCHUNK cycles), 2 result held.
   int             m_phase = 0;
   int             m_left  = 0;
   logic [W-1:0]   m_sum   = '0;
   logic           m_cout  = 1'b0;
   logic           m_ovf   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_left  <= 0;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               {m_ovf, m_cout, m_sum} <= ref_add(a, b, cin, sub);
               m_left  <= NCHUNK;
               m_phase <= 1;
            end
            1: begin
               m_left <= m_left - 1;
               if (m_left == 1) m_phase <= 2;
            end
            2: if (out_ready) m_phase <= 0;
            default: m_phase <= 0;
         endcase
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      chk("mdl_in_ready", 64'(in_ready), 64'(m_phase == 0));
      chk("mdl_busy", 64'(busy), 64'(m_phase != 0));
      chk("mdl_out_valid", 64'(out_valid), 64'(m_phase == 2));
      if (m_phase == 2) begin
         chk("mdl_sum", 64'(sum), 64'(m_sum));
         chk("mdl_cout", 64'(cout), 64'(m_cout));
         chk("mdl_ovf", 64'(ovf), 64'(m_ovf));
      end
   end

   task automatic scramble();
      a   = $urandom();
      b   = $urandom();
      cin = 1'($urandom_range(1, 0));
      sub = 1'($urandom_range(1, 0));
   endtask

   // One operation: accept, latency, result, optional backpressure, handoff.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci,
                         input logic tsub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int hold, input bit scr);
      int n;
      a = ta; b = tb_v; cin = tci; sub = tsub; in_valid = 1'b1;
      chk("pre_accept_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      if (scr) scramble(); else in_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (scr) scramble();
         if (out_valid) break;
      end
      chk("latency", 64'(n), 64'(NCHUNK));
      chk("sum", 64'(sum), 64'(es));
      chk("cout", 64'(cout), 64'(ec));
      chk("ovf", 64'(ovf), 64'(eo));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         if (scr) scramble();
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_sum", 64'(sum), 64'(es));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("handoff_in_ready", 64'(in_ready), 64'd1);
      chk("handoff_out_valid", 64'(out_valid), 64'd0);
      chk("handoff_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      // Pin the reference model with hand-computed values.
      chk("ref_3p4", 64'(ref_add(32'h3, 32'h4, 1'b0, 1'b0)), 64'h0_0000_0007);
      chk("ref_ripple", 64'(ref_add(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'h1_0000_0000);
      chk("ref_ovf", 64'(ref_add(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0)), 64'h2_8000_0000);
      chk("ref_sub", 64'(ref_add(32'h5, 32'h7, 1'b0, 1'b1)), 64'h0_FFFF_FFFE);

      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
      run_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
      // sub ignores cin; equal operands give zero with no borrow
      run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
      // most negative minus one overflows
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
      // backpressure for 10 cycles
      run_op(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 32'h3333_3334, 1'b0, 1'b0, 10, 1'b0);

      // reset in the middle of RUN (after chunks 0 and 1)
      a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("midrun_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_sum", 64'(sum), 64'd0);
      chk("midrst_cout", 64'(cout), 64'd0);
      chk("midrst_ovf", 64'(ovf), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0, 1'b0);

      // operands change every cycle after accept, in_valid held through RUN/DONE
      run_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 3, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
